// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state, load/store encodings and request helpers for dmem_access_unit
package dmem_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;
    // Unsupported load encodings are treated like bytes, so they never trap as misaligned.
    function automatic logic is_aligned(input logic web, input logic [1:0] size,
                                        input logic [2:0] funct3, input logic [1:0] off);
        logic half;
        logic word;
        half = web ? (funct3 == F3_LH || funct3 == F3_LHU) : (size == SZ_HALF);
        word = web ? (funct3 == F3_LW) : (size == SZ_WORD);
        return !(half && off[0]) && !(word && off != 2'b00);
    endfunction
    function automatic logic [31:0] store_mask(input logic [1:0] size);
        return size == SZ_WORD ? 32'hFFFF_FFFF :
               size == SZ_HALF ? 32'h0000_FFFF :
               size == SZ_BYTE ? 32'h0000_00FF : 32'h0000_0000;
    endfunction
endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// load_extend: lane-aligns a raw SRAM word and sign/zero-extends it per load type
module load_extend
    import dmem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] sh;
    always_comb begin
        sh   = rdata >> {off, 3'b000};
        data = funct3 == F3_LB  ? {{24{sh[7]}}, sh[7:0]} :
               funct3 == F3_LH  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == F3_LW  ? sh :
               funct3 == F3_LBU ? {24'b0, sh[7:0]} :
               funct3 == F3_LHU ? {16'b0, sh[15:0]} : rdata;
    end
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store sequencer between the pipeline and a single-port SRAM
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int MEM_AW  = 14,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic              i_web,
    input  logic [1:0]        i_bweb_pre,
    input  logic [2:0]        i_funct3,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_ld_valid,
    output logic [31:0]       o_ld_data,
    output logic              o_misalign,
    output logic              o_timeout,
    output logic              o_mem_req,
    input  logic              i_mem_gnt,
    output logic              o_mem_web,
    output logic [31:0]       o_mem_bweb,
    output logic [MEM_AW-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_rvalid,
    input  logic [31:0]       i_mem_rdata
);
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_n;
    logic              web_q;
    logic [1:0]        size_q;
    logic [2:0]        f3_q;
    logic [MEM_AW+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       ld_data_q;
    logic [31:0]       ext;
    logic [CW-1:0]     cnt;
    logic              misalign_q;
    logic              timeout_q;
    logic              aligned;
    logic              accept;
    logic              expire;
    logic              unused_addr;

    assign unused_addr = ^i_addr[31:MEM_AW+2];
    assign aligned     = is_aligned(i_web, i_bweb_pre, i_funct3, i_addr[1:0]);
    assign accept      = state == IDLE && i_valid && aligned;
    // A response arriving in the last wait cycle still completes the load normally.
    assign expire      = state == WAIT && !i_mem_rvalid && cnt == CW'(TIMEOUT - 1);

    load_extend u_ext (
        .rdata  (i_mem_rdata),
        .off    (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (ext)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? REQ : IDLE;
            REQ:     state_n = i_mem_gnt ? (web_q ? WAIT : DONE) : REQ;
            WAIT:    state_n = (i_mem_rvalid || expire) ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            web_q      <= 1'b0;
            size_q     <= SZ_NONE;
            f3_q       <= F3_LB;
            addr_q     <= '0;
            wdata_q    <= '0;
            ld_data_q  <= '0;
            cnt        <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (accept) begin
                web_q   <= i_web;
                size_q  <= i_bweb_pre;
                f3_q    <= i_funct3;
                addr_q  <= i_addr[MEM_AW+1:0];
                wdata_q <= i_wdata;
            end
            cnt        <= state != WAIT ? '0 : cnt == CW'(TIMEOUT) ? cnt : cnt + CW'(1);
            ld_data_q  <= (state == WAIT && i_mem_rvalid) ? ext : expire ? '0 : ld_data_q;
            misalign_q <= state == IDLE && i_valid && !aligned;
            timeout_q  <= expire;
        end
    end

    always_comb begin
        o_stall     = accept || state == REQ || state == WAIT;
        o_ld_valid  = state == DONE && web_q;
        o_ld_data   = ld_data_q;
        o_misalign  = misalign_q;
        o_timeout   = timeout_q;
        o_mem_req   = state == REQ;
        o_mem_web   = state == REQ ? web_q : 1'b1;
        o_mem_addr  = state == REQ ? addr_q[MEM_AW+1:2] : '0;
        o_mem_bweb  = (state == REQ && !web_q) ? ~(store_mask(size_q) << {addr_q[1:0], 3'b000}) : '1;
        o_mem_wdata = (state == REQ && !web_q) ? wdata_q << {addr_q[1:0], 3'b000} : '0;
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed vector table plus hand sequences for timeout, reset and back-to-back cases
module tb_dmem_access_unit;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        i_web;
    logic [1:0]  i_bweb_pre;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic        o_stall;
    logic        o_ld_valid;
    logic [31:0] o_ld_data;
    logic        o_misalign;
    logic        o_timeout;
    logic        o_mem_req;
    logic        i_mem_gnt;
    logic        o_mem_web;
    logic [31:0] o_mem_bweb;
    logic [13:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;

    int n_vec = 0;
    int n_miss = 0;

    typedef struct {
        logic        web;
        logic [1:0]  bp;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gd;
        int          rd;
        logic        mis;
        logic [31:0] e_addr;
        logic [31:0] e_bweb;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
    } vec_t;

    vec_t vecs[14];

    dmem_access_unit dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .i_web        (i_web),
        .i_bweb_pre   (i_bweb_pre),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_stall      (o_stall),
        .o_ld_valid   (o_ld_valid),
        .o_ld_data    (o_ld_data),
        .o_misalign   (o_misalign),
        .o_timeout    (o_timeout),
        .o_mem_req    (o_mem_req),
        .i_mem_gnt    (i_mem_gnt),
        .o_mem_web    (o_mem_web),
        .o_mem_bweb   (o_mem_bweb),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rvalid (i_mem_rvalid),
        .i_mem_rdata  (i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic web, input logic [1:0] bp, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        i_valid    = 1'b1;
        i_web      = web;
        i_bweb_pre = bp;
        i_funct3   = f3;
        i_addr     = addr;
        i_wdata    = wdata;
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        drive(v.web, v.bp, v.f3, v.addr, v.wdata);
        if (v.mis) begin
            chk("mis_stall_now", 32'(o_stall), 0);
            tick();
            chk("misalign_pulse", 32'(o_misalign), 1);
            chk("mis_no_req", 32'(o_mem_req), 0);
            chk("mis_stall", 32'(o_stall), 0);
            i_valid = 1'b0;
            tick();
            chk("misalign_clear", 32'(o_misalign), 0);
            chk("mis_no_req_after", 32'(o_mem_req), 0);
            return;
        end
        chk("stall_accept", 32'(o_stall), 1);
        tick();
        for (int i = 0; i < v.gd; i++) begin
            chk("req_hold", 32'(o_mem_req), 1);
            chk("req_stall", 32'(o_stall), 1);
            tick();
        end
        chk("mem_req", 32'(o_mem_req), 1);
        chk("mem_web", 32'(o_mem_web), 32'(v.web));
        chk("mem_addr", 32'(o_mem_addr), v.e_addr);
        chk("mem_bweb", o_mem_bweb, v.e_bweb);
        if (!v.web) chk("mem_wdata", o_mem_wdata, v.e_wdata);
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        if (v.web) begin
            for (int i = 0; i < v.rd; i++) begin
                chk("wait_stall", 32'(o_stall), 1);
                chk("wait_no_req", 32'(o_mem_req), 0);
                tick();
            end
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = v.rdata;
            tick();
            i_mem_rvalid = 1'b0;
            i_mem_rdata  = 32'h5A5A_5A5A;
        end
        i_valid = 1'b0;
        chk("done_stall", 32'(o_stall), 0);
        chk("done_ld_valid", 32'(o_ld_valid), 32'(v.web));
        chk("done_timeout", 32'(o_timeout), 0);
        if (v.web) chk("ld_data", o_ld_data, v.e_ld);
        tick();
        chk("idle_ld_valid", 32'(o_ld_valid), 0);
        chk("idle_req", 32'(o_mem_req), 0);
    endtask

    initial begin
        int n;
        //          web bp     f3      addr          wdata         rdata         gd rd mis e_addr    e_bweb        e_wdata       e_ld
        vecs[0]  = '{1'b0, 2'b11, 3'b000, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        0, 0, 1'b0, 32'h40, 32'h0000_0000, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 2'b01, 3'b000, 32'h0000_0103, 32'h0000_00AB, 32'h0,        2, 0, 1'b0, 32'h40, 32'h00FF_FFFF, 32'hAB00_0000, 32'h0};
        vecs[2]  = '{1'b0, 2'b10, 3'b000, 32'h0000_0106, 32'h0000_1234, 32'h0,        1, 0, 1'b0, 32'h41, 32'h0000_FFFF, 32'h1234_0000, 32'h0};
        vecs[3]  = '{1'b1, 2'b00, 3'b000, 32'h0000_0101, 32'h0,         32'h0000_8000, 0, 1, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FF80};
        vecs[4]  = '{1'b1, 2'b00, 3'b100, 32'h0000_0101, 32'h0,         32'h0000_8000, 1, 0, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, 32'h0000_0080};
        vecs[5]  = '{1'b1, 2'b00, 3'b001, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 3, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_8001};
        vecs[6]  = '{1'b1, 2'b00, 3'b101, 32'h0000_0102, 32'h0,         32'h8001_0000, 0, 0, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, 32'h0000_8001};
        vecs[7]  = '{1'b1, 2'b00, 3'b010, 32'h0000_0204, 32'h0,         32'hCAFE_F00D, 2, 2, 1'b0, 32'h81, 32'hFFFF_FFFF, 32'h0, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 2'b00, 3'b001, 32'h0000_0101, 32'h0,         32'h0,        0, 0, 1'b1, 32'h0,  32'h0,         32'h0, 32'h0};
        vecs[9]  = '{1'b0, 2'b11, 3'b000, 32'h0000_0102, 32'h1111_1111, 32'h0,        0, 0, 1'b1, 32'h0,  32'h0,         32'h0, 32'h0};
        vecs[10] = '{1'b1, 2'b00, 3'b010, 32'h0000_0103, 32'h0,         32'h0,        0, 0, 1'b1, 32'h0,  32'h0,         32'h0, 32'h0};
        vecs[11] = '{1'b0, 2'b01, 3'b000, 32'h0000_0003, 32'h1122_3344, 32'h0,        0, 0, 1'b0, 32'h0,  32'h00FF_FFFF, 32'h4400_0000, 32'h0};
        vecs[12] = '{1'b1, 2'b00, 3'b011, 32'h0000_0101, 32'h0,         32'h0000_8000, 0, 0, 1'b0, 32'h40, 32'hFFFF_FFFF, 32'h0, 32'h0000_8000};
        vecs[13] = '{1'b1, 2'b00, 3'b100, 32'h0001_0003, 32'h0,         32'hF100_0000, 0, 1, 1'b0, 32'h0,  32'hFFFF_FFFF, 32'h0, 32'h0000_00F1};

        i_rst_n = 1'b0; i_valid = 1'b0; i_web = 1'b0; i_bweb_pre = 2'b00; i_funct3 = 3'b000;
        i_addr = '0; i_wdata = '0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        repeat (2) tick();
        chk("rst_stall", 32'(o_stall), 0);
        chk("rst_ld_valid", 32'(o_ld_valid), 0);
        chk("rst_ld_data", o_ld_data, 0);
        chk("rst_misalign", 32'(o_misalign), 0);
        chk("rst_timeout", 32'(o_timeout), 0);
        chk("rst_mem_req", 32'(o_mem_req), 0);
        chk("rst_mem_web", 32'(o_mem_web), 1);
        chk("rst_mem_bweb", o_mem_bweb, 32'hFFFF_FFFF);
        chk("rst_mem_addr", 32'(o_mem_addr), 0);
        chk("rst_mem_wdata", o_mem_wdata, 0);
        i_rst_n = 1'b1;
        tick();

        foreach (vecs[k]) run_vec(vecs[k]);

        // back-to-back request held through DONE is only taken once the unit is idle again
        drive(1'b0, 2'b11, 3'b000, 32'h0000_0010, 32'h0000_0001);
        tick();
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        chk("b2b_done_stall", 32'(o_stall), 0);
        chk("b2b_done_req", 32'(o_mem_req), 0);
        tick();
        chk("b2b_idle_req", 32'(o_mem_req), 0);
        chk("b2b_idle_stall", 32'(o_stall), 1);
        tick();
        chk("b2b_second_req", 32'(o_mem_req), 1);
        chk("b2b_second_addr", 32'(o_mem_addr), 32'h4);
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        i_valid = 1'b0;
        tick();

        // timeout: rvalid withheld; expect exactly 255 stalled wait cycles
        drive(1'b1, 2'b00, 3'b010, 32'h0000_0200, 32'h0);
        tick();
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        n = 0;
        while (o_stall && n < 400) begin
            n++;
            tick();
        end
        i_valid = 1'b0;
        chk("to_wait_cycles", 32'(n), 255);
        chk("to_pulse", 32'(o_timeout), 1);
        chk("to_ld_data", o_ld_data, 0);
        chk("to_ld_valid", 32'(o_ld_valid), 1);
        tick();
        chk("to_pulse_end", 32'(o_timeout), 0);
        chk("to_idle_stall", 32'(o_stall), 0);
        chk("to_idle_req", 32'(o_mem_req), 0);

        // rvalid in the 255th wait cycle beats the timeout
        drive(1'b1, 2'b00, 3'b010, 32'h0000_0200, 32'h0);
        tick();
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        repeat (254) tick();
        chk("race_still_wait", 32'(o_stall), 1);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'h1234_5678;
        tick();
        i_mem_rvalid = 1'b0;
        i_valid = 1'b0;
        chk("race_timeout", 32'(o_timeout), 0);
        chk("race_ld_valid", 32'(o_ld_valid), 1);
        chk("race_ld_data", o_ld_data, 32'h1234_5678);
        tick();

        // reset while waiting abandons the load
        drive(1'b1, 2'b00, 3'b010, 32'h0000_0300, 32'h0);
        tick();
        i_mem_gnt = 1'b1;
        tick();
        i_mem_gnt = 1'b0;
        tick();
        chk("rw_in_wait", 32'(o_stall), 1);
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        tick();
        i_rst_n = 1'b1;
        chk("rw_stall", 32'(o_stall), 0);
        chk("rw_ld_valid", 32'(o_ld_valid), 0);
        chk("rw_mem_req", 32'(o_mem_req), 0);
        chk("rw_bweb", o_mem_bweb, 32'hFFFF_FFFF);
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hFFFF_FFFF;
        tick();
        i_mem_rvalid = 1'b0;
        chk("rw_late_rvalid", 32'(o_ld_valid), 0);
        tick();
        chk("rw_late_ld_valid", 32'(o_ld_valid), 0);
        chk("rw_late_stall", 32'(o_stall), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
